// File: rtl/data_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Shared types and constants for the data-memory controller: FSM state
// encoding, access-size encodings and the default bus timeout.
// -----------------------------------------------------------------------------
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Cycles allowed in REQ+RESP before the access is abandoned with a fault.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Valid/ready request bus with a single-cycle response pulse.
//   bus_req_valid/ready  request handshake
//   bus_req_write        1 store, 0 load
//   bus_req_addr         word-aligned byte address
//   bus_req_wdata/strb   lane-aligned store data and byte enables
//   bus_resp_valid       one-cycle response (load data or store ack)
//   bus_resp_rdata       load word
// master: the controller; slave: the memory/bus side.
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if;

  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_strb;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_strb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_strb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for a 32-bit data port.
//   addr_lo_i      address bits [1:0]
//   size_i         0 byte, 1 half, 2 word, 3 reserved
//   is_unsigned_i  zero-extend loads when 1
//   wdata_i        right-aligned store data
//   rdata_i        raw bus load word
//   strb_o         byte enables for the access
//   wdata_o        store data replicated into its byte lanes
//   rdata_o        selected lane, sign/zero-extended to 32 bits
//   misaligned_o   access cannot be issued (bad alignment or reserved size)
// -----------------------------------------------------------------------------
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] lane;

  // Bring the addressed lane down to bit 0 before extension.
  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    strb_o       = 4'b0000;
    wdata_o      = 32'h0;
    rdata_o      = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        strb_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~is_unsigned_i & lane[7]}}, lane[7:0]};
      end
      SIZE_HALF: begin
        strb_o       = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{~is_unsigned_i & lane[15]}}, lane[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      SIZE_WORD: begin
        strb_o       = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = |addr_lo_i;
      end
      default: begin
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Converts the core's single-cycle load/store request into a valid/ready bus
// transaction, stalls the core until the response arrives and returns the
// lane-selected, extended load data for exactly one (DONE) cycle.
//   clk, reset                 clock, synchronous active-high reset
//   data_addr                  byte address from the core
//   should_read_mem/write_mem  load/store request (both high = store)
//   mem_write_data             right-aligned store data
//   mem_size, mem_unsigned     access size and load extension mode
//   mem_read_data              extended load data (valid in DONE)
//   stall                      core holds PC and request while high
//   fault                      one-cycle pulse: misalignment/reserved size/timeout
//   bus                        request/response bus (master side)
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            data_addr,
  input  logic                   should_read_mem,
  input  logic                   should_write_mem,
  input  logic [31:0]            mem_write_data,
  input  logic [1:0]             mem_size,
  input  logic                   mem_unsigned,
  output logic [31:0]            mem_read_data,
  output logic                   stall,
  output logic                   fault,
  data_mem_ctrl_if.master        bus
);

  // Wide enough to hold TIMEOUT itself on the final counted cycle.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         strb_q, strb_d;
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               fault_pend_q, fault_pend_d;

  logic               access;
  logic               timeout_hit;
  logic [1:0]         al_addr;
  logic [1:0]         al_size;
  logic               al_uns;
  logic [3:0]         al_strb;
  logic [31:0]        al_wdata;
  logic [31:0]        al_rdata;
  logic               al_misaligned;

  assign access = should_read_mem | should_write_mem;

  // A single aligner serves both directions: in IDLE it steers the incoming
  // request; afterwards it extends the bus word using the latched fields.
  assign al_addr = (state_q == IDLE) ? data_addr[1:0] : addr_q[1:0];
  assign al_size = (state_q == IDLE) ? mem_size       : size_q;
  assign al_uns  = (state_q == IDLE) ? mem_unsigned   : uns_q;

  mem_lane_align u_align (
    .addr_lo_i     (al_addr),
    .size_i        (al_size),
    .is_unsigned_i (al_uns),
    .wdata_i       (mem_write_data),
    .rdata_i       (bus.bus_resp_rdata),
    .strb_o        (al_strb),
    .wdata_o       (al_wdata),
    .rdata_o       (al_rdata),
    .misaligned_o  (al_misaligned)
  );

  // Counter holds the number of REQ/RESP cycles already spent, so this is
  // true on the TIMEOUT-th such cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rdata_d      = rdata_q;
    fault_pend_d = fault_pend_q;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (al_misaligned) begin
            state_d      = DONE;
            fault_pend_d = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            state_d      = REQ;
            fault_pend_d = 1'b0;
            addr_d       = data_addr;
            wdata_d      = al_wdata;
            strb_d       = al_strb;
            write_d      = should_write_mem;
            size_d       = mem_size;
            uns_d        = mem_unsigned;
          end
        end
      end
      REQ: begin
        if (timeout_hit) begin
          state_d      = DONE;
          fault_pend_d = 1'b1;
          rdata_d      = 32'h0;
        end else if (bus.bus_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // A response on the last permitted cycle still completes the access.
        if (bus.bus_resp_valid) begin
          state_d = DONE;
          if (!write_q) rdata_d = al_rdata;
        end else if (timeout_hit) begin
          state_d      = DONE;
          fault_pend_d = 1'b1;
          rdata_d      = 32'h0;
        end
      end
      DONE: begin
        state_d      = IDLE;
        fault_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if ((TIMEOUT != 0) && ((state_q == REQ) || (state_q == RESP))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      strb_q       <= 4'h0;
      write_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      uns_q        <= 1'b0;
      rdata_q      <= 32'h0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rdata_q      <= rdata_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  assign bus.bus_req_valid = (state_q == REQ);
  assign bus.bus_req_write = write_q;
  assign bus.bus_req_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_req_wdata = wdata_q;
  assign bus.bus_req_strb  = strb_q;

  assign stall         = access & (state_q != DONE);
  assign fault         = (state_q == DONE) & fault_pend_q;
  assign mem_read_data = rdata_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sits directly downstream of the core's data-memory port and sits between the core and the external data bus.
- Accepts the core's single-cycle load/store request (address, read/write strobes, write data, size, signedness).
- Drives a valid/ready request bus with byte strobes and waits for a variable-latency response.
- Stalls the core (joined into its PC no_update) until the access completes, then returns sign/zero-extended load data.

Parameters:
- TIMEOUT, 255, max cycles spent in REQ+RESP before a bus fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge
- reset  in  1  synchronous, active-high
- data_addr  in  32  byte address from the core ALU
- should_read_mem  in  1  core load request
- should_write_mem  in  1  core store request
- mem_write_data  in  32  store data, right-aligned
- mem_size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as fault)
- mem_unsigned  in  1  zero-extend loads when 1
- mem_read_data  out  32  extended load data to the core
- stall  out  1  core must hold PC and keep its request stable
- fault  out  1  one-cycle pulse: misalignment, reserved size or timeout
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_write  out  1  1 store, 0 load
- bus_req_addr  out  32  word address (data_addr with [1:0] forced to 0)
- bus_req_wdata  out  32  store data shifted into its byte lanes
- bus_req_strb  out  4  byte enables
- bus_resp_valid  in  1  single-cycle response pulse (load data or store ack)
- bus_resp_rdata  in  32  load word

Behaviour:
- Reset: state IDLE; timeout counter 0; all registered outputs 0. This gives bus_req_valid=0, fault=0, mem_read_data=0.
- Definition: access = should_read_mem | should_write_mem. If both are high, the access is treated as a write.
- stall = access & (state != DONE). It is combinational, so it rises in the same cycle the core presents the request.
- IDLE:
  - access and legal alignment -> latch addr, wdata, strb, write, size and unsigned; go to REQ.
  - access and illegal alignment -> go to DONE with fault_pending.
  - Illegal alignment means half with addr[0]=1, word with addr[1:0]!=0, or size 3.
  - No access -> stay in IDLE.
- REQ:
  - bus_req_valid=1; the request fields are held stable until ready.
  - On bus_req_valid & bus_req_ready -> go to RESP; bus_req_valid drops the next cycle.
- RESP:
  - Wait for bus_resp_valid, which must arrive no earlier than the cycle after the handshake.
  - On bus_resp_valid -> capture the extended rdata (loads only) into the mem_read_data register; go to DONE.
- DONE:
  - stall=0 and mem_read_data is valid for exactly this cycle, while the core advances its PC.
  - fault=1 this cycle if fault_pending; a faulted load returns 0.
  - Always returns to IDLE next cycle.
  - The next instruction's request is evaluated in IDLE, so back-to-back accesses each incur the full sequence.
- Minimum stall: 3 cycles (IDLE, REQ with ready=1, RESP with response in the first cycle), then DONE.
- Lane rules:
  - Byte: strb = 1 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - Half: strb = 3 << addr[1:0]; wdata = {2{wd[15:0]}}.
  - Word: strb = 4'hF; wdata as given.
  - Loads select the lane by addr[1:0], then sign- or zero-extend from bit 7 or bit 15.
  - Load strb reflects the size, informational only.
- Timeout (TIMEOUT>0):
  - The counter increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT, drop bus_req_valid, go to DONE with fault_pending and data 0. The counter clears on entering IDLE.
  - A bus_resp_valid arriving later in IDLE or REQ of another access is ignored. Stray responses are always ignored outside RESP.
- Reset mid-operation:
  - bus_req_valid=0 from the cycle after reset is sampled; the state returns to IDLE.
  - Outstanding bus responses after reset are ignored.
- Request withdrawal: the core must keep its request stable while stall=1. Behaviour when access drops in REQ/RESP is undefined, but the transaction still completes on the bus.

Decomposition:
- Shared package holds:
  - State enum: IDLE=0, REQ=1, RESP=2, DONE=3.
  - Size encodings: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
  - TIMEOUT default.
- One combinational sub-module, mem_lane_align:
  - Inputs: addr[1:0], size, unsigned, raw write data, raw read word.
  - Outputs: strb, shifted wdata, extended rdata, misaligned flag.
- The FSM, counter and registers live in data_mem_ctrl.

Test Plan:
- Word load, addr 0x100, ready=1 in REQ, resp one cycle later with rdata 0xDEADBEEF -> stall high 3 cycles; DONE shows mem_read_data=0xDEADBEEF with stall=0, fault=0.
- Signed byte load, addr 0x103, rdata 0x80112233 -> strb 4'b1000, mem_read_data=0xFFFFFF80. The same access with mem_unsigned=1 -> 0x00000080.
- Half store, addr 0x202, data 0x0000ABCD, ready held low 4 cycles -> bus_req_valid stable for 5 cycles, strb 4'b1100, wdata 0xABCDABCD, bus_req_addr 0x200; DONE after the ack.
- Misaligned word load, addr 0x101 -> no bus_req_valid; stall 1 cycle, then DONE with fault=1, mem_read_data=0.
- TIMEOUT=8, ready=1, no response -> fault pulse in DONE after 8 counted cycles. A late bus_resp_valid in the following IDLE is ignored (state stays IDLE, data unchanged).
- Reset asserted during RESP, then a bus_resp_valid arrives -> state IDLE, outputs 0, no fault, response ignored. A subsequent word load completes normally.
